// File: rtl/risc16_eu_if.sv
// risc16_eu_if -- memory bus between the RISC16 execution unit and memory.
//   D_in    : read data from memory into the EU
//   Address : memory address driven by the EU
//   D_out   : write data driven by the EU
//   mem_we  : memory write strobe driven by the EU
// Modports: master = execution unit side, slave = memory side.
interface risc16_eu_if;
  logic [15:0] D_in;
  logic [15:0] Address;
  logic [15:0] D_out;
  logic        mem_we;

  modport master (input D_in, output Address, output D_out, output mem_we);
  modport slave  (output D_in, input Address, input D_out, input mem_we);
endinterface

// File: rtl/risc16_eu.sv
// risc16_eu -- 16-bit RISC execution unit: 8x16 register file, ALU with
// N/Z/C flags, program counter and instruction register.
// Ports:
//   clk, reset        : rising-edge clock, synchronous active-high reset
//   W_Adr/R_Adr/S_Adr : write / R-port / S-port register select
//   adr_sel           : 0 -> Address=PC, 1 -> Address=Rd
//   s_sel             : 0 -> write ALU result, 1 -> write D_in
//   pc_ld/pc_inc/pc_sel : PC load (branch or Rd), increment, load source
//   ir_ld             : load IR from D_in
//   rw_en, mw_en      : register write enable, memory write strobe
//   alu_op            : ALU function
//   bus (master)      : D_in, Address, D_out, mem_we
//   IR, N, Z, C       : instruction register and registered flags
// Build option: define RISC16_R0_ZERO_EN to hard-wire R0 to zero.
module risc16_eu (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  W_Adr,
  input  logic [2:0]  R_Adr,
  input  logic [2:0]  S_Adr,
  input  logic        adr_sel,
  input  logic        s_sel,
  input  logic        pc_ld,
  input  logic        pc_inc,
  input  logic        pc_sel,
  input  logic        ir_ld,
  input  logic        rw_en,
  input  logic        mw_en,
  input  logic [3:0]  alu_op,
  risc16_eu_if.master bus,
  output logic [15:0] IR,
  output logic        N,
  output logic        Z,
  output logic        C
);

  logic [15:0] rf_q [8];
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic        n_q, z_q, c_q;
  logic        n_d, z_d, c_d;
  logic [15:0] rd, sd, wdata;
  logic [16:0] alu_r;
  logic        wr_en;
  logic        flag_upd;

`ifdef RISC16_R0_ZERO_EN
  assign rd    = (R_Adr == 3'd0) ? 16'h0000 : rf_q[R_Adr];
  assign sd    = (S_Adr == 3'd0) ? 16'h0000 : rf_q[S_Adr];
  assign wr_en = rw_en && (W_Adr != 3'd0);
`else
  assign rd    = rf_q[R_Adr];
  assign sd    = rf_q[S_Adr];
  assign wr_en = rw_en;
`endif

  // Bit 16 carries carry-out (add/inc), borrow (sub/dec) or the shifted-out bit.
  always_comb begin
    alu_r = 17'd0;
    case (alu_op)
      4'b0000: alu_r = {1'b0, rd};
      4'b0001: alu_r = {1'b0, sd};
      4'b0010: alu_r = {1'b0, rd} + {1'b0, sd};
      4'b0011: alu_r = {1'b0, rd} - {1'b0, sd};
      4'b0100: alu_r = {1'b0, rd} + 17'd1;
      4'b0101: alu_r = {1'b0, rd} - 17'd1;
      4'b0110: alu_r = {rd[0], 1'b0, rd[15:1]};
      4'b0111: alu_r = {rd, 1'b0};
      4'b1000: alu_r = {1'b0, rd & sd};
      4'b1001: alu_r = {1'b0, rd | sd};
      4'b1010: alu_r = {1'b0, rd ^ sd};
      4'b1011: alu_r = {1'b0, ~rd};
      default: alu_r = 17'd0;
    endcase
  end

  // Flags follow arithmetic/shift ops only, and not during fetch or branch cycles.
  assign flag_upd = !alu_op[3] && (alu_op[2:1] != 2'b00) && !ir_ld && !pc_ld;

  always_comb begin
    n_d  = n_q;
    z_d  = z_q;
    c_d  = c_q;
    ir_d = ir_q;
    pc_d = pc_q;
    if (flag_upd) begin
      n_d = alu_r[15];
      z_d = (alu_r[15:0] == 16'h0000);
      c_d = alu_r[16];
    end
    if (ir_ld) ir_d = bus.D_in;
    // Branch offset uses the IR held before this edge, even when IR reloads.
    if (pc_ld) pc_d = pc_sel ? rd : pc_q + {{8{ir_q[7]}}, ir_q[7:0]};
    else if (pc_inc) pc_d = pc_q + 16'd1;
  end

  assign wdata = s_sel ? bus.D_in : alu_r[15:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= 16'h0000;
      ir_q <= 16'h0000;
      n_q  <= 1'b0;
      z_q  <= 1'b0;
      c_q  <= 1'b0;
      for (int i = 0; i < 8; i++) rf_q[i] <= 16'h0000;
    end else begin
      pc_q <= pc_d;
      ir_q <= ir_d;
      n_q  <= n_d;
      z_q  <= z_d;
      c_q  <= c_d;
      if (wr_en) rf_q[W_Adr] <= wdata;
    end
  end

  // While reset is held the PC-sourced address reads as zero.
  assign bus.Address = adr_sel ? rd : (reset ? 16'h0000 : pc_q);
  assign bus.D_out   = sd;
  assign bus.mem_we  = mw_en;
  assign IR          = ir_q;
  assign N           = n_q;
  assign Z           = z_q;
  assign C           = c_q;

endmodule

// File: tb/tb_risc16_eu.sv
module tb_risc16_eu;
  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  W_Adr, R_Adr, S_Adr;
  logic        adr_sel, s_sel, pc_ld, pc_inc, pc_sel, ir_ld, rw_en, mw_en;
  logic [3:0]  alu_op;
  logic [15:0] IR;
  logic        N, Z, C;
  logic [15:0] v;
  int          n_checks = 0;
  int          n_errors = 0;

  risc16_eu_if bus ();

  risc16_eu dut (
    .clk(clk), .reset(reset), .W_Adr(W_Adr), .R_Adr(R_Adr), .S_Adr(S_Adr),
    .adr_sel(adr_sel), .s_sel(s_sel), .pc_ld(pc_ld), .pc_inc(pc_inc),
    .pc_sel(pc_sel), .ir_ld(ir_ld), .rw_en(rw_en), .mw_en(mw_en),
    .alu_op(alu_op), .bus(bus.master), .IR(IR), .N(N), .Z(Z), .C(C)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    reset = 1'b0; W_Adr = 3'd0; R_Adr = 3'd0; S_Adr = 3'd0;
    adr_sel = 1'b0; s_sel = 1'b0; pc_ld = 1'b0; pc_inc = 1'b0; pc_sel = 1'b0;
    ir_ld = 1'b0; rw_en = 1'b0; mw_en = 1'b0; alu_op = 4'd0; bus.D_in = 16'h0000;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    idle(); W_Adr = a; s_sel = 1'b1; bus.D_in = d; rw_en = 1'b1;
    tick(); idle();
  endtask

  task automatic rd_r(input logic [2:0] a, output logic [15:0] d);
    idle(); adr_sel = 1'b1; R_Adr = a;
    @(negedge clk); d = bus.Address; adr_sel = 1'b0;
  endtask

  task automatic get_pc(output logic [15:0] d);
    idle(); @(negedge clk); d = bus.Address;
  endtask

  task automatic alu(input logic [3:0] op, input logic [2:0] r, input logic [2:0] s,
                     input logic [2:0] w, input logic en);
    idle(); alu_op = op; R_Adr = r; S_Adr = s; W_Adr = w; rw_en = en;
    tick(); idle();
  endtask

  task automatic set_pc(input logic [15:0] d);
    wr(3'd7, d); R_Adr = 3'd7; pc_ld = 1'b1; pc_sel = 1'b1;
    tick(); idle();
  endtask

  function automatic logic [15:0] flags();
    return {13'd0, N, Z, C};
  endfunction

  initial begin
    // Reset with every control active: in-flight write must be discarded.
    idle();
    reset = 1'b1; rw_en = 1'b1; W_Adr = 3'd1; s_sel = 1'b1; bus.D_in = 16'hABCD;
    mw_en = 1'b1; pc_inc = 1'b1; ir_ld = 1'b1;
    @(negedge clk);
    check("rst_addr", bus.Address, 16'h0000);
    check("rst_mem_we", {15'd0, bus.mem_we}, 16'h0001);
    tick(); tick(); idle();
    get_pc(v); check("rst_pc", v, 16'h0000);
    check("rst_ir", IR, 16'h0000);
    check("rst_flags", flags(), 16'h0000);
    rd_r(3'd1, v); check("rst_r1", v, 16'h0000);

    // Fetch
    idle(); ir_ld = 1'b1; pc_inc = 1'b1; bus.D_in = 16'h0123; tick(); idle();
    check("fetch_ir", IR, 16'h0123);
    get_pc(v); check("fetch_pc", v, 16'h0001);
    check("fetch_flags", flags(), 16'h0000);

    // Add with carry-out to zero
    wr(3'd1, 16'hFFFF); wr(3'd2, 16'h0001);
    alu(4'b0010, 3'd1, 3'd2, 3'd3, 1'b1);
    rd_r(3'd3, v); check("add_r3", v, 16'h0000);
    check("add_flags", flags(), 16'h0003);

    // Compare (sub, no write)
    wr(3'd1, 16'h0002); wr(3'd2, 16'h0005);
    alu(4'b0011, 3'd1, 3'd2, 3'd3, 1'b0);
    rd_r(3'd3, v); check("cmp_r3", v, 16'h0000);
    rd_r(3'd1, v); check("cmp_r1", v, 16'h0002);
    check("cmp_flags", flags(), 16'h0005);

    // Flags hold during IR load, and for logic ops
    idle(); alu_op = 4'b0010; R_Adr = 3'd1; S_Adr = 3'd2; ir_ld = 1'b1; bus.D_in = 16'h00FE;
    tick(); idle();
    check("hold_ir_flags", flags(), 16'h0005);
    check("hold_ir", IR, 16'h00FE);
    alu(4'b1000, 3'd1, 3'd2, 3'd7, 1'b1);
    rd_r(3'd7, v); check("and_r7", v, 16'h0000);
    check("and_flags", flags(), 16'h0005);

    // Branches
    set_pc(16'h0010);
    get_pc(v); check("pc_set", v, 16'h0010);
    idle(); pc_ld = 1'b1; pc_inc = 1'b1; tick(); idle();
    get_pc(v); check("br_back", v, 16'h000E);
    wr(3'd4, 16'h0200);
    R_Adr = 3'd4; pc_ld = 1'b1; pc_sel = 1'b1; tick(); idle();
    get_pc(v); check("jmp_rd", v, 16'h0200);
    idle(); ir_ld = 1'b1; pc_ld = 1'b1; bus.D_in = 16'h0005; tick(); idle();
    get_pc(v); check("br_old_ir", v, 16'h01FE);
    check("br_new_ir", IR, 16'h0005);

    // PC wrap both ways
    set_pc(16'hFFFF);
    idle(); pc_inc = 1'b1; tick(); idle();
    get_pc(v); check("pc_wrap_inc", v, 16'h0000);
    idle(); ir_ld = 1'b1; bus.D_in = 16'h00FF; tick(); idle();
    pc_ld = 1'b1; tick(); idle();
    get_pc(v); check("pc_wrap_br", v, 16'hFFFF);

    // ALU sweep
    wr(3'd1, 16'hFFFF);
    alu(4'b0100, 3'd1, 3'd0, 3'd3, 1'b1);
    rd_r(3'd3, v); check("inc_r", v, 16'h0000);
    check("inc_flags", flags(), 16'h0003);
    wr(3'd1, 16'h8001);
    alu(4'b0111, 3'd1, 3'd0, 3'd4, 1'b1);
    rd_r(3'd4, v); check("shl_r", v, 16'h0002);
    check("shl_flags", flags(), 16'h0001);
    alu(4'b0101, 3'd3, 3'd0, 3'd5, 1'b1);
    rd_r(3'd5, v); check("dec_r", v, 16'hFFFF);
    check("dec_flags", flags(), 16'h0005);
    alu(4'b0110, 3'd1, 3'd0, 3'd6, 1'b1);
    rd_r(3'd6, v); check("shr_r", v, 16'h4000);
    check("shr_flags", flags(), 16'h0001);
    alu(4'b0010, 3'd4, 3'd6, 3'd7, 1'b1);
    rd_r(3'd7, v); check("add_nc_r", v, 16'h4002);
    check("add_nc_flags", flags(), 16'h0000);
    alu(4'b1001, 3'd1, 3'd4, 3'd7, 1'b1);
    rd_r(3'd7, v); check("or_r", v, 16'h8003);
    alu(4'b1010, 3'd6, 3'd1, 3'd7, 1'b1);
    rd_r(3'd7, v); check("xor_r", v, 16'hC001);
    alu(4'b1011, 3'd4, 3'd0, 3'd7, 1'b1);
    rd_r(3'd7, v); check("not_r", v, 16'hFFFD);
    alu(4'b0001, 3'd0, 3'd6, 3'd7, 1'b1);
    rd_r(3'd7, v); check("pass_s", v, 16'h4000);
    alu(4'b0000, 3'd4, 3'd0, 3'd7, 1'b1);
    rd_r(3'd7, v); check("pass_r", v, 16'h0002);
    alu(4'b1100, 3'd1, 3'd1, 3'd7, 1'b1);
    rd_r(3'd7, v); check("op_c_zero", v, 16'h0000);
    wr(3'd7, 16'h5555);
    alu(4'b1111, 3'd1, 3'd1, 3'd7, 1'b1);
    rd_r(3'd7, v); check("op_f_zero", v, 16'h0000);
    check("logic_flags_hold", flags(), 16'h0000);
    alu(4'b0011, 3'd4, 3'd4, 3'd7, 1'b0);
    check("sub_eq_flags", flags(), 16'h0002);

    // Read of the register being written returns the old value
    wr(3'd5, 16'h1111);
    idle(); adr_sel = 1'b1; R_Adr = 3'd5; W_Adr = 3'd5; s_sel = 1'b1;
    bus.D_in = 16'h2222; rw_en = 1'b1;
    @(negedge clk); check("raw_old", bus.Address, 16'h1111);
    tick(); idle();
    rd_r(3'd5, v); check("raw_new", v, 16'h2222);

    // Memory path
    wr(3'd5, 16'h0040);
    idle(); adr_sel = 1'b1; R_Adr = 3'd5; s_sel = 1'b1; bus.D_in = 16'hBEEF;
    W_Adr = 3'd6; rw_en = 1'b1;
    @(negedge clk); check("mem_addr", bus.Address, 16'h0040);
    tick(); idle();
    mw_en = 1'b1; S_Adr = 3'd6;
    @(negedge clk);
    check("mem_dout", bus.D_out, 16'hBEEF);
    check("mem_we_hi", {15'd0, bus.mem_we}, 16'h0001);
    idle(); @(negedge clk);
    check("mem_we_lo", {15'd0, bus.mem_we}, 16'h0000);

    // R0 behaviour
    wr(3'd0, 16'h1234);
    rd_r(3'd0, v);
`ifdef RISC16_R0_ZERO_EN
    check("r0_rd", v, 16'h0000);
    idle(); S_Adr = 3'd0; @(negedge clk); check("r0_sd", bus.D_out, 16'h0000);
`else
    check("r0_rd", v, 16'h1234);
    idle(); S_Adr = 3'd0; @(negedge clk); check("r0_sd", bus.D_out, 16'h1234);
`endif

    // Reset mid-instruction clears state and drops the write
    idle(); reset = 1'b1; rw_en = 1'b1; W_Adr = 3'd5; s_sel = 1'b1; bus.D_in = 16'hABCD;
    tick(); idle();
    rd_r(3'd5, v); check("rst2_r5", v, 16'h0000);
    rd_r(3'd6, v); check("rst2_r6", v, 16'h0000);
    get_pc(v); check("rst2_pc", v, 16'h0000);
    check("rst2_ir", IR, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/risc16_eu.md
RISC16_EU -- requirements
Module: risc16_eu

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge clock; reset in 1, synchronous active-high reset; W_Adr in 3, write register; R_Adr in 3, R-port register; S_Adr in 3, S-port register.
REQ-002 SHALL have ports: adr_sel in 1, address source; s_sel in 1, write-data source; pc_ld in 1, PC load; pc_inc in 1, PC increment; pc_sel in 1, PC load source; ir_ld in 1, IR load; rw_en in 1, register write; mw_en in 1, memory write strobe; alu_op in 4, ALU function.
REQ-003 SHALL have ports: D_in in 16, memory read data; Address out 16; D_out out 16, memory write data; mem_we out 1; IR out 16; N, Z, C out 1 each, registered flags.

Function
REQ-004 SHALL contain an 8x16 register file with combinational read ports Rd=R[R_Adr] and Sd=R[S_Adr], written on clk rise when rw_en=1.
REQ-005 SHALL drive Address=PC when adr_sel=0 and Address=Rd when adr_sel=1, combinationally.
REQ-006 SHALL drive D_out=Sd and mem_we=mw_en combinationally.
REQ-007 SHALL write the ALU result to R[W_Adr] when s_sel=0 and D_in when s_sel=1.
REQ-008 SHALL implement alu_op: 0000 Rd; 0001 Sd; 0010 Rd+Sd; 0011 Rd-Sd; 0100 Rd+1; 0101 Rd-1; 0110 Rd>>1 logical; 0111 Rd<<1; 1000 Rd&Sd; 1001 Rd|Sd; 1010 Rd^Sd; 1011 ~Rd; 1100-1111 result 0.
REQ-009 SHALL compute all arithmetic modulo 2^16 with C from bit 16: add/inc carry-out; sub/dec borrow (C=1 when Rd<Sd unsigned, or Rd=0 for dec); shl C=Rd[15]; shr C=Rd[0].
REQ-010 SHALL register N=result[15], Z=(result==0), C per REQ-009 on clk rise only when alu_op is 0010-0111 and ir_ld=0 and pc_ld=0; otherwise flags hold.
REQ-011 SHALL update flags even with rw_en=0 (compare).
REQ-012 SHALL load IR<=D_in on clk rise when ir_ld=1, else hold.
REQ-013 SHALL update PC on clk rise with priority: pc_ld=1 -> (pc_sel=0: PC+sign-extended IR[7:0]; pc_sel=1: Rd); else pc_inc=1 -> PC+1; else hold.
REQ-014 SHALL wrap PC arithmetic modulo 2^16 (0xFFFF+1=0x0000; 0x0000+0xFF=0xFFFF).
REQ-015 SHALL, with ir_ld=1 and pc_ld=1 simultaneously, use the pre-edge IR for branch offset and load the new IR.
REQ-016 SHALL return the pre-edge value on a read of the address being written in the same cycle.

Reset
REQ-017 SHALL on clk rise with reset=1 clear PC, IR, N, Z, C and all eight registers to 0, overriding every other control.
REQ-018 SHALL during reset drive Address=0 (adr_sel=0), mem_we=mw_en; assertion mid-instruction discards the in-flight write.

Configuration
REQ-019 SHALL, when macro RISC16_R0_ZERO_EN is defined, hard-wire R0: reads return 0x0000 and writes to R0 ignored.
REQ-020 SHALL, when RISC16_R0_ZERO_EN is undefined, treat R0 as an ordinary register.

Verification
REQ-021 Reset, then ir_ld=1, pc_inc=1, D_in=0x0123 -> IR=0x0123, PC=0x0001, flags 000.
REQ-022 R1=0xFFFF, R2=0x0001, alu_op=0010, W=3, rw_en=1 -> R3=0x0000, N=0 Z=1 C=1.
REQ-023 R1=0x0002, R2=0x0005, alu_op=0011, rw_en=0 -> registers unchanged, N=1 Z=0 C=1.
REQ-024 PC=0x0010, IR[7:0]=0xFE, pc_ld=1, pc_sel=0, pc_inc=1 -> PC=0x000E; then pc_sel=1, R_Adr=4, R4=0x0200 -> PC=0x0200.
REQ-025 adr_sel=1, R_Adr=5, R5=0x0040, s_sel=1, D_in=0xBEEF, W=6, rw_en=1 -> Address=0x0040, R6=0xBEEF; mw_en=1, S_Adr=6 -> D_out=0xBEEF, mem_we=1.
REQ-026 With RISC16_R0_ZERO_EN: write 0x1234 to R0 -> Rd(R_Adr=0)=0x0000; without macro -> 0x1234.
